// File: rtl/vpu_pkg.sv
// Shared definitions for the multi-ported vector register file.
// Holds the register geometry (VLEN, NREG, AW), default port counts and
// the vector / byte-enable types used by the interface, top and merge unit.
package vpu_pkg;
  localparam int VLEN    = 64;
  localparam int NREG    = 32;
  localparam int AW      = $clog2(NREG);
  localparam int NBYTE   = VLEN / 8;
  localparam int NRD_DEF = 3;
  localparam int NWR_DEF = 2;

  typedef logic [VLEN-1:0]  vreg_t;
  typedef logic [NBYTE-1:0] vbe_t;
endpackage

// File: rtl/vpu_vrf_mp_if.sv
// Bus bundle between issue/writeback (master) and the register file (slave).
//   rd_addr_i / rd_data_o  : NRD combinational read ports
//   v0_o                   : dedicated mask register read
//   wr_*_i                 : NWR byte-masked write ports, higher index wins
//   rsv_en_i / rsv_addr_i  : destination reservation
//   busy_o                 : pending-write scoreboard
//   wr_conflict_o          : overlapping-write pulse
interface vpu_vrf_mp_if #(
  parameter int NRD = vpu_pkg::NRD_DEF,
  parameter int NWR = vpu_pkg::NWR_DEF
) ();
  import vpu_pkg::*;

  logic [NRD-1:0][AW-1:0]    rd_addr_i;
  logic [NRD-1:0][VLEN-1:0]  rd_data_o;
  logic [VLEN-1:0]           v0_o;
  logic [NWR-1:0]            wr_en_i;
  logic [NWR-1:0][AW-1:0]    wr_addr_i;
  logic [NWR-1:0][NBYTE-1:0] wr_be_i;
  logic [NWR-1:0][VLEN-1:0]  wr_data_i;
  logic [NWR-1:0]            wr_last_i;
  logic                      rsv_en_i;
  logic [AW-1:0]             rsv_addr_i;
  logic [NREG-1:0]           busy_o;
  logic                      wr_conflict_o;

  modport master (
    output rd_addr_i, wr_en_i, wr_addr_i, wr_be_i, wr_data_i, wr_last_i,
           rsv_en_i, rsv_addr_i,
    input  rd_data_o, v0_o, busy_o, wr_conflict_o
  );

  modport slave (
    input  rd_addr_i, wr_en_i, wr_addr_i, wr_be_i, wr_data_i, wr_last_i,
           rsv_en_i, rsv_addr_i,
    output rd_data_o, v0_o, busy_o, wr_conflict_o
  );
endinterface

// File: rtl/vpu_vrf_wmerge.sv
// Combinational priority byte merge for one register (REG_IDX).
//   i_en/i_addr/i_be/i_data : all write ports
//   o_data : merged byte data (valid where o_hit is set)
//   o_hit  : bytes written this cycle by some port
//   o_ovl  : two or more ports hit the same byte of this register
// Used both for the storage update and for the same-cycle read bypass.
module vpu_vrf_wmerge
  import vpu_pkg::*;
#(
  parameter int NWR     = 2,
  parameter int REG_IDX = 0
) (
  input  logic [NWR-1:0]            i_en,
  input  logic [NWR-1:0][AW-1:0]    i_addr,
  input  logic [NWR-1:0][NBYTE-1:0] i_be,
  input  logic [NWR-1:0][VLEN-1:0]  i_data,
  output vreg_t                     o_data,
  output vbe_t                      o_hit,
  output logic                      o_ovl
);
  always_comb begin
    o_data = '0;
    o_hit  = '0;
    o_ovl  = 1'b0;
    // Ascending scan so the highest-index port is the last to land a byte.
    for (int p = 0; p < NWR; p++) begin
      if (i_en[p] && (i_addr[p] == AW'(REG_IDX))) begin
        for (int b = 0; b < NBYTE; b++) begin
          if (i_be[p][b]) begin
            if (o_hit[b]) o_ovl = 1'b1;
            o_hit[b]          = 1'b1;
            o_data[b*8 +: 8]  = i_data[p][b*8 +: 8];
          end
        end
      end
    end
  end
endmodule

// File: rtl/vpu_vrf_mp.sv
// Multi-ported vector register file with byte-masked writes, optional
// same-cycle write-to-read bypass and a pending-write scoreboard.
//   clk_i  : clock, all state on posedge
//   rst_i  : synchronous active-high reset
//   bus    : vpu_vrf_mp_if slave (read/write ports, reservation, status)
// Parameters: NRD read ports, NWR write ports, BYPASS (1 = reads see
// same-cycle writes). NRD/NWR must match the connected interface.
module vpu_vrf_mp
  import vpu_pkg::*;
#(
  parameter int NRD    = 3,
  parameter int NWR    = 2,
  parameter bit BYPASS = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  vpu_vrf_mp_if.slave  bus
);
  logic [NREG-1:0][VLEN-1:0]  r_vrf;
  logic [NREG-1:0]            r_busy;
  logic                       r_conflict;

  logic [NREG-1:0][VLEN-1:0]  w_mdat;
  logic [NREG-1:0][NBYTE-1:0] w_hit;
  logic [NREG-1:0]            w_ovl;
  logic [NREG-1:0][VLEN-1:0]  w_view;
  logic [NREG-1:0]            w_clr;
  logic [NREG-1:0]            w_set;
  logic [NRD-1:0][VLEN-1:0]   w_rd;

  // One merge unit per register; addresses >= NREG match none of them,
  // so out-of-range writes fall away naturally.
  for (genvar gr = 0; gr < NREG; gr++) begin : g_reg
    vpu_vrf_wmerge #(.NWR(NWR), .REG_IDX(gr)) u_wm (
      .i_en   (bus.wr_en_i),
      .i_addr (bus.wr_addr_i),
      .i_be   (bus.wr_be_i),
      .i_data (bus.wr_data_i),
      .o_data (w_mdat[gr]),
      .o_hit  (w_hit[gr]),
      .o_ovl  (w_ovl[gr])
    );
  end

  // Read view per register: stored value, with winning write bytes
  // overlaid when bypassing. Writes are dropped in reset, so no bypass then.
  always_comb begin
    w_view = r_vrf;
    for (int r = 0; r < NREG; r++) begin
      for (int b = 0; b < NBYTE; b++) begin
        if (BYPASS && !rst_i && w_hit[r][b])
          w_view[r][b*8 +: 8] = w_mdat[r][b*8 +: 8];
      end
    end
  end

  // Read mux: unmatched (out-of-range) addresses return 0.
  always_comb begin
    w_rd = '0;
    for (int k = 0; k < NRD; k++) begin
      for (int r = 0; r < NREG; r++) begin
        if (bus.rd_addr_i[k] == AW'(r)) w_rd[k] = w_view[r];
      end
    end
  end

  // Scoreboard events. A last beat clears even with all-zero byte enables.
  always_comb begin
    w_clr = '0;
    w_set = '0;
    for (int r = 0; r < NREG; r++) begin
      for (int p = 0; p < NWR; p++) begin
        if (bus.wr_en_i[p] && bus.wr_last_i[p] && (bus.wr_addr_i[p] == AW'(r)))
          w_clr[r] = 1'b1;
      end
      if (bus.rsv_en_i && (bus.rsv_addr_i == AW'(r))) w_set[r] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vrf      <= '0;
      r_busy     <= '0;
      r_conflict <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        for (int b = 0; b < NBYTE; b++) begin
          if (w_hit[r][b]) r_vrf[r][b*8 +: 8] <= w_mdat[r][b*8 +: 8];
        end
      end
      // Set applied after clear so a same-cycle reservation wins.
      r_busy     <= (r_busy & ~w_clr) | w_set;
      r_conflict <= |w_ovl;
    end
  end

  assign bus.rd_data_o     = w_rd;
  assign bus.v0_o          = w_view[0];
  assign bus.busy_o        = r_busy;
  assign bus.wr_conflict_o = r_conflict;
endmodule

// File: tb/tb_vpu_vrf_mp.sv
module tb_vpu_vrf_mp;
  import vpu_pkg::*;
  localparam int NRD = 3;
  localparam int NWR = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [NRD-1:0][AW-1:0]    t_rd_addr;
  logic [NWR-1:0]            t_wr_en;
  logic [NWR-1:0][AW-1:0]    t_wr_addr;
  logic [NWR-1:0][NBYTE-1:0] t_wr_be;
  logic [NWR-1:0][VLEN-1:0]  t_wr_data;
  logic [NWR-1:0]            t_wr_last;
  logic                      t_rsv_en;
  logic [AW-1:0]             t_rsv_addr;

  vpu_vrf_mp_if #(.NRD(NRD), .NWR(NWR)) bus_b ();
  vpu_vrf_mp_if #(.NRD(NRD), .NWR(NWR)) bus_n ();

  assign bus_b.rd_addr_i = t_rd_addr;  assign bus_n.rd_addr_i = t_rd_addr;
  assign bus_b.wr_en_i   = t_wr_en;    assign bus_n.wr_en_i   = t_wr_en;
  assign bus_b.wr_addr_i = t_wr_addr;  assign bus_n.wr_addr_i = t_wr_addr;
  assign bus_b.wr_be_i   = t_wr_be;    assign bus_n.wr_be_i   = t_wr_be;
  assign bus_b.wr_data_i = t_wr_data;  assign bus_n.wr_data_i = t_wr_data;
  assign bus_b.wr_last_i = t_wr_last;  assign bus_n.wr_last_i = t_wr_last;
  assign bus_b.rsv_en_i  = t_rsv_en;   assign bus_n.rsv_en_i  = t_rsv_en;
  assign bus_b.rsv_addr_i = t_rsv_addr; assign bus_n.rsv_addr_i = t_rsv_addr;

  vpu_vrf_mp #(.NRD(NRD), .NWR(NWR), .BYPASS(1'b1)) u_byp (
    .clk_i(clk), .rst_i(rst), .bus(bus_b.slave));
  vpu_vrf_mp #(.NRD(NRD), .NWR(NWR), .BYPASS(1'b0)) u_nob (
    .clk_i(clk), .rst_i(rst), .bus(bus_n.slave));

  // Reference model: architectural register contents, busy set, conflict flag.
  vreg_t           m_mem [NREG];
  vreg_t           m_nxt [NREG];
  logic [NREG-1:0] m_busy;
  logic            m_conf;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Contents after this cycle's writes land; later ports overwrite earlier.
  task automatic model_next();
    for (int r = 0; r < NREG; r++) m_nxt[r] = m_mem[r];
    if (!rst)
      for (int p = 0; p < NWR; p++)
        if (t_wr_en[p])
          for (int b = 0; b < NBYTE; b++)
            if (t_wr_be[p][b]) m_nxt[t_wr_addr[p]][b*8 +: 8] = t_wr_data[p][b*8 +: 8];
  endtask

  // Bypass read sees the post-write value; non-bypass sees the old one.
  task automatic check_comb();
    model_next();
    if (!rst) begin
      for (int k = 0; k < NRD; k++) begin
        chk($sformatf("rd%0d_byp a%0d", k, t_rd_addr[k]), bus_b.rd_data_o[k], m_nxt[t_rd_addr[k]]);
        chk($sformatf("rd%0d_nob a%0d", k, t_rd_addr[k]), bus_n.rd_data_o[k], m_mem[t_rd_addr[k]]);
      end
      chk("v0_byp", bus_b.v0_o, m_nxt[0]);
      chk("v0_nob", bus_n.v0_o, m_mem[0]);
    end
  endtask

  task automatic edge_update();
    logic [NREG-1:0] nb;
    logic            nc;
    model_next();
    nb = m_busy;
    nc = 1'b0;
    for (int p = 0; p < NWR; p++)
      if (t_wr_en[p] && t_wr_last[p]) nb[t_wr_addr[p]] = 1'b0;
    if (t_rsv_en) nb[t_rsv_addr] = 1'b1;
    for (int p = 0; p < NWR; p++)
      for (int q = p + 1; q < NWR; q++)
        if (t_wr_en[p] && t_wr_en[q] && t_wr_addr[p] == t_wr_addr[q] &&
            (t_wr_be[p] & t_wr_be[q]) != '0) nc = 1'b1;
    @(posedge clk);
    if (rst) begin
      for (int r = 0; r < NREG; r++) m_mem[r] = '0;
      m_busy = '0;
      m_conf = 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) m_mem[r] = m_nxt[r];
      m_busy = nb;
      m_conf = nc;
    end
    #1;
    chk("busy_byp", 64'(bus_b.busy_o), 64'(m_busy));
    chk("busy_nob", 64'(bus_n.busy_o), 64'(m_busy));
    chk("conf_byp", 64'(bus_b.wr_conflict_o), 64'(m_conf));
    chk("conf_nob", 64'(bus_n.wr_conflict_o), 64'(m_conf));
  endtask

  task automatic idle();
    t_wr_en = '0; t_wr_addr = '0; t_wr_be = '0; t_wr_data = '0; t_wr_last = '0;
    t_rsv_en = 1'b0; t_rsv_addr = '0; t_rd_addr = '0;
  endtask

  typedef struct {
    logic [1:0]  en;
    logic [4:0]  wa0; logic [7:0] be0; logic [63:0] wd0; logic l0;
    logic [4:0]  wa1; logic [7:0] be1; logic [63:0] wd1; logic l1;
    logic        rsv; logic [4:0] ra;
    logic [4:0]  rd0;
    logic        rs;
    logic [63:0] e_byp, e_nob;
    logic [31:0] e_busy;
    logic        e_conf;
  } vec_t;

  function automatic vec_t V(
    input logic [1:0] en,
    input logic [4:0] wa0, input logic [7:0] be0, input logic [63:0] wd0, input logic l0,
    input logic [4:0] wa1, input logic [7:0] be1, input logic [63:0] wd1, input logic l1,
    input logic rsv, input logic [4:0] ra, input logic [4:0] rd0, input logic rs,
    input logic [63:0] e_byp, input logic [63:0] e_nob, input logic [31:0] e_busy,
    input logic e_conf);
    vec_t v;
    v.en = en; v.wa0 = wa0; v.be0 = be0; v.wd0 = wd0; v.l0 = l0;
    v.wa1 = wa1; v.be1 = be1; v.wd1 = wd1; v.l1 = l1;
    v.rsv = rsv; v.ra = ra; v.rd0 = rd0; v.rs = rs;
    v.e_byp = e_byp; v.e_nob = e_nob; v.e_busy = e_busy; v.e_conf = e_conf;
    return v;
  endfunction

  localparam logic [63:0] A = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] B = 64'hBBBB_BBBB_BBBB_BBBB;
  localparam logic [63:0] D5 = 64'h1122_3344_5566_7788;
  localparam logic [63:0] S7 = 64'h7777_7777_7777_7777;

  vec_t tbl [15];

  initial begin
    // en, wa0,be0,wd0,l0, wa1,be1,wd1,l1, rsv,ra, rd0, rst, e_byp, e_nob, e_busy, e_conf
    tbl[0]  = V(2'b00, 0,8'h00,0,0, 0,8'h00,0,0, 0,0, 5,0, 0, 0, 0, 0);
    tbl[1]  = V(2'b01, 5,8'hFF,D5,0, 0,8'h00,0,0, 0,0, 5,0, D5, 0, 0, 0);
    tbl[2]  = V(2'b00, 0,8'h00,0,0, 0,8'h00,0,0, 0,0, 5,0, D5, D5, 0, 0);
    tbl[3]  = V(2'b11, 3,8'h0F,A,0, 3,8'h0C,B,0, 0,0, 3,0,
                64'h0000_0000_BBBB_AAAA, 0, 0, 1);
    tbl[4]  = V(2'b00, 0,8'h00,0,0, 0,8'h00,0,0, 0,0, 3,0,
                64'h0000_0000_BBBB_AAAA, 64'h0000_0000_BBBB_AAAA, 0, 0);
    tbl[5]  = V(2'b11, 3,8'hF0,64'h1111_1111_1111_1111,0, 3,8'h0F,64'h2222_2222_2222_2222,0,
                0,0, 3,0, 64'h1111_1111_2222_2222, 64'h0000_0000_BBBB_AAAA, 0, 0);
    tbl[6]  = V(2'b00, 0,8'h00,0,0, 0,8'h00,0,0, 0,0, 3,0,
                64'h1111_1111_2222_2222, 64'h1111_1111_2222_2222, 0, 0);
    tbl[7]  = V(2'b00, 0,8'h00,0,0, 0,8'h00,0,0, 1,7, 7,0, 0, 0, 32'h80, 0);
    tbl[8]  = V(2'b01, 7,8'hFF,S7,0, 0,8'h00,0,0, 0,0, 7,0, S7, 0, 32'h80, 0);
    tbl[9]  = V(2'b10, 0,8'h00,0,0, 7,8'h00,64'hFFFF_FFFF_FFFF_FFFF,1, 1,7, 7,0, S7, S7, 32'h80, 0);
    tbl[10] = V(2'b01, 7,8'h00,0,1, 0,8'h00,0,0, 0,0, 7,0, S7, S7, 0, 0);
    tbl[11] = V(2'b10, 0,8'h00,0,0, 0,8'hFF,64'hFF00,0, 1,9, 0,0, 64'hFF00, 0, 32'h200, 0);
    tbl[12] = V(2'b01, 4,8'hFF,64'h4444_4444_4444_4444,1, 0,8'h00,0,0, 1,4, 4,1, 0, 0, 0, 0);
    tbl[13] = V(2'b00, 0,8'h00,0,0, 0,8'h00,0,0, 0,0, 0,0, 0, 0, 0, 0);
    tbl[14] = V(2'b00, 0,8'h00,0,0, 0,8'h00,0,0, 0,0, 4,0, 0, 0, 0, 0);

    idle();
    for (int r = 0; r < NREG; r++) m_mem[r] = '0;
    m_busy = '0;
    m_conf = 1'b0;

    // Reset for two edges, then sweep every register on all read ports.
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("busy_after_rst", 64'(bus_b.busy_o), 64'h0);
    chk("conf_after_rst", 64'(bus_b.wr_conflict_o), 64'h0);
    for (int i = 0; i < 11; i++) begin
      for (int k = 0; k < NRD; k++) t_rd_addr[k] = AW'((i * NRD + k) % NREG);
      #1;
      for (int k = 0; k < NRD; k++) begin
        chk($sformatf("rst_rd_byp a%0d", t_rd_addr[k]), bus_b.rd_data_o[k], 64'h0);
        chk($sformatf("rst_rd_nob a%0d", t_rd_addr[k]), bus_n.rd_data_o[k], 64'h0);
      end
    end

    // Directed table, cross-checked against the model as well.
    foreach (tbl[i]) begin
      idle();
      rst          = tbl[i].rs;
      t_wr_en      = tbl[i].en;
      t_wr_addr[0] = tbl[i].wa0; t_wr_be[0] = tbl[i].be0;
      t_wr_data[0] = tbl[i].wd0; t_wr_last[0] = tbl[i].l0;
      t_wr_addr[1] = tbl[i].wa1; t_wr_be[1] = tbl[i].be1;
      t_wr_data[1] = tbl[i].wd1; t_wr_last[1] = tbl[i].l1;
      t_rsv_en     = tbl[i].rsv; t_rsv_addr = tbl[i].ra;
      t_rd_addr[0] = tbl[i].rd0; t_rd_addr[1] = 5'd1; t_rd_addr[2] = 5'd31;
      #1;
      if (!tbl[i].rs) begin
        chk($sformatf("vec%0d rd_byp", i), bus_b.rd_data_o[0], tbl[i].e_byp);
        chk($sformatf("vec%0d rd_nob", i), bus_n.rd_data_o[0], tbl[i].e_nob);
      end
      check_comb();
      edge_update();
      chk($sformatf("vec%0d busy", i), 64'(bus_b.busy_o), 64'(tbl[i].e_busy));
      chk($sformatf("vec%0d conf", i), 64'(bus_b.wr_conflict_o), 64'(tbl[i].e_conf));
      rst = 1'b0;
    end

    // Randomized traffic on a small address window to force collisions.
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 79) == 0);
      for (int p = 0; p < NWR; p++) begin
        t_wr_en[p]   = $urandom_range(0, 1) == 1;
        t_wr_addr[p] = AW'($urandom_range(0, 7));
        t_wr_be[p]   = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
        t_wr_data[p] = {$urandom, $urandom};
        t_wr_last[p] = $urandom_range(0, 2) == 0;
      end
      t_rsv_en   = $urandom_range(0, 2) == 0;
      t_rsv_addr = AW'($urandom_range(0, 7));
      for (int k = 0; k < NRD; k++)
        t_rd_addr[k] = AW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, NREG-1)
                                                       : $urandom_range(0, 7));
      #1;
      check_comb();
      edge_update();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
